// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// follows redirects and presents fetched instructions through a stall buffer.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] inflight_pc;
    logic [31:0] inflight_d;
    logic        kill_q;
    logic        kill_d;
    logic        valid_d;
    logic [31:0] ifpc_d;
    logic [31:0] inst_d;
    logic [31:0] cnt_d;

    logic redir;
    logic fire;
    logic resp;
    logic load;
    logic consume;

    assign imem_req  = (state_q == REQ) && (!if_valid || !stall);
    assign imem_addr = pc_q;
    assign if_pc4    = if_pc + 32'd4;

    assign redir   = redirect_valid && (state_q != IDLE);
    assign fire    = imem_req && imem_gnt;
    assign resp    = (state_q == WAIT) && imem_rvalid;
    assign load    = resp && !kill_q && !redir;
    assign consume = if_valid && !stall && !load;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_pc;
        kill_d     = kill_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (fire) begin
                    inflight_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = WAIT;
                    // a redirect racing the grant makes the granted word stale
                    if (redir) kill_d = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                    kill_d  = 1'b0;
                end else if (redir) begin
                    kill_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redir) pc_d = {redirect_pc[31:2], 2'b00};
    end

    always_comb begin
        valid_d = if_valid;
        ifpc_d  = if_pc;
        inst_d  = if_inst;
        cnt_d   = fetch_cnt;
        if (consume) begin
            valid_d = 1'b0;
            cnt_d   = fetch_cnt + 32'd1;
        end
        if (load) begin
            valid_d = 1'b1;
            ifpc_d  = inflight_pc;
            inst_d  = imem_rdata;
        end
        if (redir) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            inflight_pc <= 32'd0;
            kill_q      <= 1'b0;
            if_valid    <= 1'b0;
            if_pc       <= 32'd0;
            if_inst     <= 32'd0;
            fetch_cnt   <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inflight_pc <= inflight_d;
            kill_q      <= kill_d;
            if_valid    <= valid_d;
            if_pc       <= ifpc_d;
            if_inst     <= inst_d;
            fetch_cnt   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic against a
// transaction-level model of the fetch stream.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;
    logic [31:0] fetch_cnt;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic [31:0] w_inst;
    logic [31:0] w_cnt;

    fetch_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4),
        .if_inst(if_inst), .fetch_cnt(fetch_cnt)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .if_valid(w_valid), .if_pc(w_pc), .if_pc4(w_pc4),
        .if_inst(w_inst), .fetch_cnt(w_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model of the fetch stream
    logic        m_up;
    logic        m_ov;
    logic        m_stale;
    logic [31:0] m_oa;
    logic        m_bv;
    logic [31:0] m_bpc;
    logic [31:0] m_binst;
    logic [31:0] m_nf;
    logic [31:0] m_cnt;

    logic [31:0] dq[$];
    logic [31:0] wq[$];
    logic [31:0] pcq[$];
    logic [31:0] w_first_pc;
    logic [31:0] w_first_pc4;
    logic        w_seen;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic model_reset();
        m_up = 1'b0; m_ov = 1'b0; m_stale = 1'b0; m_oa = '0;
        m_bv = 1'b0; m_bpc = '0; m_binst = '0;
        m_nf = 32'h0; m_cnt = '0;
        dq.delete(); wq.delete(); pcq.delete();
        w_seen = 1'b0; w_first_pc = '0; w_first_pc4 = '0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        stall = 0; redirect_valid = 0; imem_gnt = 0; imem_rvalid = 0;
        #1;
        chk("rst_valid", if_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", if_pc, 0);
        chk("rst_inst", if_inst, 0);
        chk("rst_pc4", if_pc4, 32'd4);
        chk("rst_cnt", fetch_cnt, 0);
        chk("rst_waddr", w_addr, 32'hFFFF_FFFC);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick(input logic st, input logic rd,
                        input logic [31:0] rpc, input logic gn,
                        input logic rv, input logic [31:0] dat);
        logic er, fire, redir, resp, load, cons;
        stall = st; redirect_valid = rd; redirect_pc = rpc;
        imem_gnt = gn; imem_rvalid = rv; imem_rdata = dat;
        #1;
        er = m_up && !m_ov && (!m_bv || !st);
        chk("req", imem_req, er);
        chk("addr", imem_addr, m_nf);
        chk("valid", if_valid, m_bv);
        chk("cnt", fetch_cnt, m_cnt);
        if (m_bv) begin
            chk("if_pc", if_pc, m_bpc);
            chk("if_inst", if_inst, m_binst);
            chk("if_pc4", if_pc4, m_bpc + 32'd4);
        end
        if (imem_req && gn) dq.push_back(imem_addr);
        if (w_req && gn) wq.push_back(w_addr);
        if (if_valid) pcq.push_back(if_pc);
        if (w_valid && !w_seen) begin
            w_seen = 1'b1; w_first_pc = w_pc; w_first_pc4 = w_pc4;
        end
        fire  = er && gn;
        redir = rd && m_up;
        resp  = m_ov && rv;
        load  = resp && !m_stale && !redir;
        cons  = m_bv && !st && !load;
        if (cons) m_cnt++;
        if (redir) m_bv = 1'b0;
        else if (load) begin
            m_bv = 1'b1; m_bpc = m_oa; m_binst = dat;
        end else if (cons) m_bv = 1'b0;
        if (resp) m_ov = 1'b0;
        if (fire) begin
            m_ov = 1'b1; m_oa = m_nf; m_stale = redir;
        end else if (m_ov && redir) m_stale = 1'b1;
        if (redir) m_nf = {rpc[31:2], 2'b00};
        else if (fire) m_nf = m_nf + 32'd4;
        m_up = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_run(input int n, input int sp, input int rdp);
        for (int i = 0; i < n; i++) begin
            logic st, gn, rv, rd;
            st = ($urandom_range(99) < sp);
            gn = ($urandom_range(99) < 60);
            rv = m_ov ? ($urandom_range(99) < 50) : ($urandom_range(99) < 10);
            rd = ($urandom_range(99) < rdp);
            tick(st, rd, $urandom, gn, rv, $urandom);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // straight-line fetch, gnt always, rvalid one cycle after gnt
        for (int i = 0; i < 8; i++)
            tick(0, 0, 0, 1, m_ov, 32'h1000_0000 + i);
        chk("t1_ngnt", dq.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_gaddr", qat(dq, i), 4 * i);
        for (int i = 0; i < 3; i++) chk("t1_ifpc", qat(pcq, i), 4 * i);
        chk("t1_cnt", fetch_cnt, 3);
        chk("t1_wrap_g0", qat(wq, 0), 32'hFFFF_FFFC);
        chk("t1_wrap_g1", qat(wq, 1), 32'h0);
        chk("t1_wrap_pc", w_first_pc, 32'hFFFF_FFFC);
        chk("t1_wrap_pc4", w_first_pc4, 32'h0);

        // stall with a full buffer
        tick(0, 0, 0, 1, 1, 32'hC0C0_C0C0);
        chk("t2_full", if_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 1, 0, 0);
            chk("t2_noreq", imem_req, 0);
            chk("t2_hold", if_inst, 32'hC0C0_C0C0);
        end
        tick(0, 0, 0, 1, 0, 0);
        chk("t2_cnt", fetch_cnt, 4);
        chk("t2_next", qat(dq, dq.size() - 1), 32'h10);

        // redirect while waiting: the late response is dropped
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 0);
        tick(0, 1, 32'h100, 1, 0, 0);
        tick(0, 0, 0, 1, 0, 0);
        tick(0, 0, 0, 1, 1, 32'hDEAD_BEEF);
        chk("t3_drop", if_valid, 0);
        chk("t3_addr", imem_addr, 32'h100);
        tick(0, 0, 0, 1, 0, 0);
        chk("t3_gnt", qat(dq, dq.size() - 1), 32'h100);
        tick(0, 0, 0, 1, 1, 32'h0000_0013);
        chk("t3_pc", if_pc, 32'h100);

        // redirect in the same cycle as the grant for 0x8
        do_reset();
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, m_ov, 32'h2000_0000 + i);
        tick(0, 1, 32'h203, 1, 0, 0);
        chk("t4_gaddr", qat(dq, dq.size() - 1), 32'h8);
        chk("t4_flush", if_valid, 0);
        chk("t4_cnt", fetch_cnt, 2);
        tick(0, 0, 0, 1, 1, 32'h1234_5678);
        chk("t4_drop", if_valid, 0);
        tick(0, 0, 0, 1, 0, 0);
        chk("t4_next", qat(dq, dq.size() - 1), 32'h200);

        // reset while waiting, stray responses after release
        do_reset();
        tick(0, 0, 0, 0, 1, 32'hBADB_AD00);
        tick(0, 0, 0, 0, 1, 32'hBADB_AD01);
        tick(0, 0, 0, 1, 1, 32'hBADB_AD02);
        chk("t5_valid", if_valid, 0);
        chk("t5_first", qat(dq, 0), 32'h0);

        rand_run(1500, 30, 5);
        do_reset();
        rand_run(1500, 50, 10);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
